// File: rtl/linear_layer_start_fifo_srl.sv
// Start-token FIFO for the Linear_Layer_i4xi4_q dataflow region: shift-register storage
// addressed by a signed occupancy pointer, with fall-through head data.

module linear_layer_start_fifo_srl_shiftreg #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] sr [0:DEPTH-1];

  // New entries enter at slot 0, so the oldest entry sits at the highest occupied slot.
  always_ff @(posedge clk) begin
    if (ce) begin
      sr[0] <= data;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[a];

endmodule

module linear_layer_start_fifo_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  localparam logic [ADDR_WIDTH:0] PTR_LAST_FREE = (ADDR_WIDTH+1)'(DEPTH - 2);

  // ptr is occupancy minus one; all-ones means empty.
  logic [ADDR_WIDTH:0]   ptr;
  logic                  full_n;
  logic                  empty_n;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] addr;

  assign push = if_write & if_write_ce & full_n;
  assign pop  = if_read & if_read_ce & empty_n;
  assign addr = ptr[ADDR_WIDTH] ? '0 : ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '1;
      full_n  <= 1'b1;
      empty_n <= 1'b0;
    end else if (push && !pop) begin
      ptr     <= ptr + 1'b1;
      empty_n <= 1'b1;
      if (ptr == PTR_LAST_FREE) full_n <= 1'b0;
    end else if (pop && !push) begin
      ptr    <= ptr - 1'b1;
      full_n <= 1'b1;
      if (ptr == '0) empty_n <= 1'b0;
    end
  end

  linear_layer_start_fifo_srl_shiftreg #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_srl (
    .clk (clk),
    .data(if_din),
    .ce  (push),
    .a   (addr),
    .q   (if_dout)
  );

  assign if_full_n         = full_n;
  assign if_empty_n        = empty_n;
  assign if_num_data_valid = ptr + 1'b1;
  assign if_fifo_cap       = (ADDR_WIDTH+1)'(DEPTH);

endmodule
